// File: rtl/mic_array_ctrl_pkg.sv
// rtl/mic_array_ctrl_pkg.sv - shared types and constants for the mic array controller
//
// Purpose: controller state encoding, snapshot bit position and the
// channel-index width helper used by the top level and the stream interface.
package mic_array_pkg;

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    WARMUP   = 2'd1,
    RUN      = 2'd2,
    STOPPING = 2'd3
  } state_t;

  // Bit position within the frame at which receiver words are snapshotted:
  // right words updated just after ws fell, left words mid-previous-frame.
  localparam int SNAP_BIT = 4;

  // Width of a mic index for n_pairs stereo receivers (2*n_pairs mics).
  function automatic int chan_w(input int n_pairs);
    return (n_pairs < 1) ? 1 : $clog2(2 * n_pairs);
  endfunction

endpackage

// File: rtl/mic_array_ctrl_if.sv
// rtl/mic_array_ctrl_if.sv - sample stream interface between controller and buffer
//
// Purpose: valid/ready sample stream carrying one mic word per transfer.
// Signals:
//   out_data  [WIDTH]            sample word
//   out_chan  [chan_w(N_PAIRS)]  mic index, 2p = left, 2p+1 = right
//   out_valid                    word available
//   out_ready                    sink accepts word
//   out_seq   [16]               frame sequence tag (only with MIC_ARRAY_CTRL_SEQ_EN)
// Modports: master = controller (source), slave = buffer (sink).
interface mic_array_ctrl_if #(
  parameter int WIDTH   = 18,
  parameter int N_PAIRS = 4
);

  logic [WIDTH-1:0]                             out_data;
  logic [mic_array_pkg::chan_w(N_PAIRS)-1:0]    out_chan;
  logic                                         out_valid;
  logic                                         out_ready;
`ifdef MIC_ARRAY_CTRL_SEQ_EN
  logic [15:0]                                  out_seq;
`endif

  modport master (
    output out_data,
    output out_chan,
    output out_valid,
`ifdef MIC_ARRAY_CTRL_SEQ_EN
    output out_seq,
`endif
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_chan,
    input  out_valid,
`ifdef MIC_ARRAY_CTRL_SEQ_EN
    input  out_seq,
`endif
    output out_ready
  );

endinterface

// File: rtl/mic_array_ctrl_i2s_clkgen.sv
// rtl/mic_array_ctrl_i2s_clkgen.sv - I2S bit clock, word select and frame position strobes
//
// Purpose: divides clk into sck, counts sck bits within a frame and drives ws.
// Ports:
//   clk, reset_n  system clock, synchronous active-low reset
//   run           1 = generate clocks; 0 = hold everything at 0
//   sck, ws       I2S bit clock and word select (0 = left slot)
//   sck_fall      1-cycle strobe: sck goes low on the next edge, bit_cnt advances
//   frame_wrap    1-cycle strobe: bit_cnt wraps to 0 on the next edge
//   snap_pt       1-cycle strobe: bit_cnt advances SNAP_BIT -> SNAP_BIT+1
module i2s_clkgen
  import mic_array_pkg::*;
#(
  parameter int SCK_DIV   = 8,
  parameter int SLOT_BITS = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic sck,
  output logic ws,
  output logic sck_fall,
  output logic frame_wrap,
  output logic snap_pt
);

  localparam int DW = $clog2(SCK_DIV);
  localparam int BW = $clog2(2 * SLOT_BITS);

  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] bit_nxt;
  logic          div_last;
  logic          bit_last;

  assign div_last   = (div_cnt == DW'(SCK_DIV - 1));
  assign bit_last   = (bit_cnt == BW'(2 * SLOT_BITS - 1));
  assign bit_nxt    = bit_last ? '0 : bit_cnt + 1'b1;

  assign sck_fall   = run & div_last & sck;
  assign frame_wrap = sck_fall & bit_last;
  assign snap_pt    = sck_fall & (bit_cnt == BW'(SNAP_BIT));

  always_ff @(posedge clk) begin
    if (!reset_n || !run) begin
      div_cnt <= '0;
      sck     <= 1'b0;
      bit_cnt <= '0;
      ws      <= 1'b0;
    end else begin
      div_cnt <= div_last ? '0 : div_cnt + 1'b1;
      if (div_last) begin
        sck <= ~sck;
      end
      // ws is registered together with bit_cnt so it only moves as sck falls.
      if (sck_fall) begin
        bit_cnt <= bit_nxt;
        ws      <= (bit_nxt >= BW'(SLOT_BITS));
      end
    end
  end

endmodule

// File: rtl/mic_array_ctrl.sv
// rtl/mic_array_ctrl.sv - I2S mic array clock/frame master and sample collector
//
// Purpose: generates shared sck/ws for N_PAIRS I2S receivers, snapshots all
// receiver words once per frame and streams them out one word per transfer.
// Optional feature: define MIC_ARRAY_CTRL_SEQ_EN to add strm.out_seq, a
// per-frame sequence tag that also counts dropped frames.
// Ports:
//   clk, reset_n        system clock, synchronous active-low reset
//   enable              run request (level)
//   sck, ws             I2S bit clock / word select to all receivers
//   data_left_in        receiver p left word at [p*WIDTH +: WIDTH]
//   data_right_in       receiver p right word, same packing
//   strm                sample stream (master side)
//   busy                state != OFF or drain pending
//   overflow, clr_ovf   sticky frame-dropped flag and its clear
module mic_array_ctrl
  import mic_array_pkg::*;
#(
  parameter int WIDTH         = 18,
  parameter int N_PAIRS       = 4,
  parameter int SCK_DIV       = 8,
  parameter int SLOT_BITS     = 32,
  parameter int WARMUP_FRAMES = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  output logic                       sck,
  output logic                       ws,
  input  logic [N_PAIRS*WIDTH-1:0]   data_left_in,
  input  logic [N_PAIRS*WIDTH-1:0]   data_right_in,
  mic_array_ctrl_if.master           strm,
  output logic                       busy,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int NCH = 2 * N_PAIRS;
  localparam int CW  = chan_w(N_PAIRS);
  localparam int FW  = (WARMUP_FRAMES < 1) ? 1 : $clog2(WARMUP_FRAMES + 1);

  state_t         state, state_nxt;
  logic           stop_from_run;
  logic [FW-1:0]  frame_cnt;
  logic           sck_fall, frame_wrap, snap_pt;
  logic           frame_end;
  logic           snap_en, snap_take, snap_drop;
  logic           valid;
  logic [CW-1:0]  chan;
  logic [WIDTH-1:0] shadow [NCH];

  i2s_clkgen #(
    .SCK_DIV   (SCK_DIV),
    .SLOT_BITS (SLOT_BITS)
  ) u_clkgen (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (state != OFF),
    .sck        (sck),
    .ws         (ws),
    .sck_fall   (sck_fall),
    .frame_wrap (frame_wrap),
    .snap_pt    (snap_pt)
  );

  assign frame_end = sck_fall & frame_wrap;

  // A frame whose snapshot point lands in STOPPING still counts when the
  // stop came out of RUN; a stop out of WARMUP never emits samples.
  assign snap_en   = (state == RUN) || ((state == STOPPING) && stop_from_run);
  assign snap_take = snap_pt & snap_en & ~valid;
  assign snap_drop = snap_pt & snap_en & valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= OFF;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OFF:      if (enable) state_nxt = WARMUP;
      WARMUP: begin
        if (!enable) begin
          state_nxt = STOPPING;
        end else if (frame_cnt == FW'(WARMUP_FRAMES)) begin
          state_nxt = RUN;
        end
      end
      RUN:      if (!enable) state_nxt = STOPPING;
      STOPPING: if (frame_end) state_nxt = OFF;
      default:  state_nxt = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stop_from_run <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      if (state != STOPPING) begin
        stop_from_run <= (state == RUN);
      end
      if (state == OFF) begin
        frame_cnt <= '0;
      end else if ((state == WARMUP) && frame_end && (frame_cnt != FW'(WARMUP_FRAMES))) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Shadow bank and drain. A new snapshot while a drain is pending is dropped
  // so the words being emitted never change under the sink.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid    <= 1'b0;
      chan     <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      if (snap_take) begin
        valid <= 1'b1;
        chan  <= '0;
        for (int p = 0; p < N_PAIRS; p++) begin
          shadow[2*p]   <= data_left_in[p*WIDTH +: WIDTH];
          shadow[2*p+1] <= data_right_in[p*WIDTH +: WIDTH];
        end
      end else if (valid && strm.out_ready) begin
        if (chan == CW'(NCH - 1)) begin
          valid <= 1'b0;
          chan  <= '0;
        end else begin
          chan <= chan + 1'b1;
        end
      end
      if (snap_drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  assign strm.out_valid = valid;
  assign strm.out_chan  = chan;
  assign strm.out_data  = shadow[chan];
  assign busy           = (state != OFF) || valid;

`ifdef MIC_ARRAY_CTRL_SEQ_EN
  logic [15:0] seq_cnt;
  logic [15:0] seq_tag;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seq_cnt <= '0;
      seq_tag <= '0;
    end else begin
      if (state == OFF) begin
        seq_cnt <= '0;
      end else if (snap_take || snap_drop) begin
        seq_cnt <= seq_cnt + 16'd1;
      end
      if (snap_take) begin
        seq_tag <= seq_cnt;
      end
    end
  end

  assign strm.out_seq = seq_tag;
`endif

endmodule
